// File: rtl/gemm_pipe_if.sv
// Operand and result streams of the GEMM pipe, bundled as one interface.
// The slave side is the pipe itself; the master side is the fetch/writeback logic.
interface gemm_pipe_if #(
  parameter int INP_WIDTH = 8,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int INP_DEPTH = 16,
  parameter int WGT_DEPTH = 256,
  parameter int ACC_DEPTH = 16
);
  localparam int I_T_WIDTH = INP_WIDTH * INP_DEPTH;
  localparam int W_T_WIDTH = WGT_WIDTH * WGT_DEPTH;
  localparam int A_T_WIDTH = ACC_WIDTH * ACC_DEPTH;
  localparam int O_T_WIDTH = INP_WIDTH * ACC_DEPTH;

  // operand stream
  logic                 s_valid;
  logic                 s_ready;
  logic                 s_reset_acc;
  logic [I_T_WIDTH-1:0] s_inp;
  logic [W_T_WIDTH-1:0] s_wgt;
  logic [A_T_WIDTH-1:0] s_acc;

  // result stream
  logic                 m_valid;
  logic                 m_ready;
  logic [A_T_WIDTH-1:0] m_acc;
  logic [O_T_WIDTH-1:0] m_out;

  modport master (
    output s_valid, s_reset_acc, s_inp, s_wgt, s_acc, m_ready,
    input  s_ready, m_valid, m_acc, m_out
  );

  modport slave (
    input  s_valid, s_reset_acc, s_inp, s_wgt, s_acc, m_ready,
    output s_ready, m_valid, m_acc, m_out
  );
endinterface

// File: rtl/gemm_pipe.sv
// Two-stage valid/ready pipeline around a combinational 1xN by NxN GEMM with
// accumulate. Stage 1 holds operands, stage 2 holds the result and its
// narrowed copy. Also counts result beats taken downstream.

// Combinational GEMM core: res[i] = acc'[i] + sum_j inp[j] * wgt[i][j], all
// terms sign-extended and summed modulo 2^ACC_WIDTH.
module gemm_op #(
  parameter int INP_WIDTH = 8,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int INP_DEPTH = 16,
  parameter int WGT_DEPTH = 256,
  parameter int ACC_DEPTH = 16
) (
  input  logic                           reset_acc,
  input  logic [INP_WIDTH*INP_DEPTH-1:0] inp,
  input  logic [WGT_WIDTH*WGT_DEPTH-1:0] wgt,
  input  logic [ACC_WIDTH*ACC_DEPTH-1:0] acc,
  output logic [ACC_WIDTH*ACC_DEPTH-1:0] res
);
  localparam int I_T_WIDTH = INP_WIDTH * INP_DEPTH;
  localparam int ROW_WIDTH = WGT_WIDTH * INP_DEPTH;

  // Dot product of the input vector with one weight row, wrapping in ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] dot_row(
    input logic [I_T_WIDTH-1:0] x,
    input logic [ROW_WIDTH-1:0] w
  );
    logic signed [ACC_WIDTH-1:0] sum;
    // NOTE: blocking '=' is correct inside functions and combinational code;
    // each statement must see the value produced by the one before it.
    sum = '0;
    for (int j = 0; j < INP_DEPTH; j++) begin
      sum = sum + ACC_WIDTH'($signed(x[j*INP_WIDTH +: INP_WIDTH]))
                * ACC_WIDTH'($signed(w[j*WGT_WIDTH +: WGT_WIDTH]));
    end
    return sum;
  endfunction

  // One output lane per accumulator element.
  for (genvar i = 0; i < ACC_DEPTH; i++) begin : g_lane
    assign res[i*ACC_WIDTH +: ACC_WIDTH] =
      (reset_acc ? {ACC_WIDTH{1'b0}} : acc[i*ACC_WIDTH +: ACC_WIDTH])
      + dot_row(inp, wgt[i*ROW_WIDTH +: ROW_WIDTH]);
  end
endmodule

module gemm_pipe #(
  parameter int INP_WIDTH = 8,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int INP_DEPTH = 16,
  parameter int WGT_DEPTH = 256,
  parameter int ACC_DEPTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gemm_pipe_if.slave           bus,
  output logic [CNT_WIDTH-1:0] op_count,
  output logic                 busy
);
  localparam int I_T_WIDTH = INP_WIDTH * INP_DEPTH;
  localparam int W_T_WIDTH = WGT_WIDTH * WGT_DEPTH;
  localparam int A_T_WIDTH = ACC_WIDTH * ACC_DEPTH;
  localparam int O_T_WIDTH = INP_WIDTH * ACC_DEPTH;

  logic                 s1_valid;
  logic                 s1_reset_acc;
  logic [I_T_WIDTH-1:0] s1_inp;
  logic [W_T_WIDTH-1:0] s1_wgt;
  logic [A_T_WIDTH-1:0] s1_acc;

  logic                 s2_valid;
  logic [A_T_WIDTH-1:0] s2_acc;
  logic [O_T_WIDTH-1:0] s2_out;

  logic                 s2_adv;
  logic                 in_ready;
  logic [A_T_WIDTH-1:0] gemm_res;
  logic [O_T_WIDTH-1:0] gemm_out;

  // Stage 2 can take a new beat when empty or when its beat leaves this edge;
  // stage 1 likewise when empty or moving up. Neither looks at s_valid.
  assign s2_adv   = !s2_valid || bus.m_ready;
  assign in_ready = !s1_valid || s2_adv;

  assign bus.s_ready = in_ready;
  assign bus.m_valid = s2_valid;
  assign bus.m_acc   = s2_acc;
  assign bus.m_out   = s2_out;
  assign busy        = s1_valid || s2_valid;

  gemm_op #(
    .INP_WIDTH (INP_WIDTH),
    .WGT_WIDTH (WGT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .INP_DEPTH (INP_DEPTH),
    .WGT_DEPTH (WGT_DEPTH),
    .ACC_DEPTH (ACC_DEPTH)
  ) u_gemm_op (
    .reset_acc (s1_reset_acc),
    .inp       (s1_inp),
    .wgt       (s1_wgt),
    .acc       (s1_acc),
    .res       (gemm_res)
  );

  // Narrowed output is the low INP_WIDTH bits of each accumulator element.
  for (genvar i = 0; i < ACC_DEPTH; i++) begin : g_narrow
    assign gemm_out[i*INP_WIDTH +: INP_WIDTH] = gemm_res[i*ACC_WIDTH +: INP_WIDTH];
  end

  // Stage 1: capture an operand beat on every input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are cleared as well as the valids, so no
      // value from before reset can ever be observed on the result bus.
      s1_valid     <= 1'b0;
      s1_reset_acc <= 1'b0;
      s1_inp       <= '0;
      s1_wgt       <= '0;
      s1_acc       <= '0;
    end else begin
      // NOTE: non-blocking '<=' for all state so every register samples the
      // pre-edge values of the others, independent of statement order.
      if (in_ready) s1_valid <= bus.s_valid;
      if (in_ready && bus.s_valid) begin
        s1_reset_acc <= bus.s_reset_acc;
        s1_inp       <= bus.s_inp;
        s1_wgt       <= bus.s_wgt;
        s1_acc       <= bus.s_acc;
      end
    end
  end

  // Stage 2: register the GEMM result when stage 1 moves up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_acc   <= '0;
      s2_out   <= '0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        s2_acc <= gemm_res;
        s2_out <= gemm_out;
      end
    end
  end

  // Count result beats taken downstream; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (s2_valid && bus.m_ready) begin
      op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_gemm_pipe.sv
// Directed bench for gemm_pipe: single beats, signed wrap, accumulator
// reset, backpressure, a full-rate stream and asynchronous reset.
module tb_gemm_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] op_count;
  logic        busy;
  int          total = 0;
  int          bad = 0;

  gemm_pipe_if #(
    .INP_WIDTH(8), .WGT_WIDTH(8), .ACC_WIDTH(32),
    .INP_DEPTH(16), .WGT_DEPTH(256), .ACC_DEPTH(16)
  ) bus ();

  gemm_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference GEMM using plain int arithmetic (32-bit, wraps).
  function automatic logic [511:0] ref_gemm(input logic [127:0] x, input logic [2047:0] w,
                                            input logic [511:0] a, input logic ra);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      int s;
      s = ra ? 0 : int'(a[i*32 +: 32]);
      for (int j = 0; j < 16; j++)
        s = s + int'(byte'(x[j*8 +: 8])) * int'(byte'(w[i*128 + j*8 +: 8]));
      r[i*32 +: 32] = s;
    end
    return r;
  endfunction

  function automatic logic [127:0] narrow(input logic [511:0] a);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[i*8 +: 8] = a[i*32 +: 8];
    return o;
  endfunction

  task automatic drive(input logic [127:0] i, input logic [2047:0] w,
                       input logic [511:0] a, input logic ra);
    bus.s_valid     = 1'b1;
    bus.s_inp       = i;
    bus.s_wgt       = w;
    bus.s_acc       = a;
    bus.s_reset_acc = ra;
  endtask

  task automatic idle;
    bus.s_valid     = 1'b0;
    bus.s_inp       = '0;
    bus.s_wgt       = '0;
    bus.s_acc       = '0;
    bus.s_reset_acc = 1'b0;
  endtask

  // Present one beat; return m_valid seen after the first edge. On return the
  // bench sits at the negedge after the second edge, with the result showing.
  task automatic send_one(input logic [127:0] i, input logic [2047:0] w,
                          input logic [511:0] a, input logic ra, output logic early);
    @(negedge clk);
    drive(i, w, a, ra);
    @(negedge clk);
    idle;
    early = bus.m_valid;
    @(negedge clk);
  endtask

  task automatic test_reset;
    idle;
    bus.m_ready = 1'b1;
    #1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    total++; if (bus.m_acc !== 512'd0) begin bad++; $display("FAIL reset_m_acc: got %h want 0", bus.m_acc); end
    total++; if (bus.m_out !== 128'd0) begin bad++; $display("FAIL reset_m_out: got %h want 0", bus.m_out); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_single;
    logic early;
    send_one({16{8'h01}}, {256{8'h01}}, {16{32'd5}}, 1'b0, early);
    total++; if (early !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", early); end
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL single_m_valid: got %b want 1", bus.m_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    total++; if (bus.m_acc !== {16{32'h15}}) begin bad++; $display("FAIL single_m_acc: got %h want %h", bus.m_acc, {16{32'h15}}); end
    total++; if (bus.m_out !== {16{8'h15}}) begin bad++; $display("FAIL single_m_out: got %h want %h", bus.m_out, {16{8'h15}}); end
    @(negedge clk);
    total++; if (op_count !== 16'd1) begin bad++; $display("FAIL single_op_count: got %0d want 1", op_count); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL single_drained: got %b want 0", bus.m_valid); end
  endtask

  task automatic test_signed_wrap;
    logic early;
    send_one(128'h80, {16{128'h80}}, {16{32'h7FFF_FFFF}}, 1'b0, early);
    total++; if (bus.m_acc !== {16{32'h8000_3FFF}}) begin bad++; $display("FAIL wrap_m_acc: got %h want %h", bus.m_acc, {16{32'h8000_3FFF}}); end
    total++; if (bus.m_out !== {16{8'hFF}}) begin bad++; $display("FAIL wrap_m_out: got %h want %h", bus.m_out, {16{8'hFF}}); end
    @(negedge clk);
    total++; if (op_count !== 16'd2) begin bad++; $display("FAIL wrap_op_count: got %0d want 2", op_count); end
  endtask

  task automatic test_reset_acc;
    logic           early;
    logic [127:0]   x;
    logic [2047:0]  w;
    logic [511:0]   exp_acc;
    logic [127:0]   exp_out;
    x = '0; w = '0; exp_acc = '0; exp_out = '0;
    for (int j = 0; j < 16; j++) begin
      x[j*8 +: 8]          = 8'(j);
      w[j*128 + j*8 +: 8]  = 8'd1;
      exp_acc[j*32 +: 32]  = 32'(j);
      exp_out[j*8 +: 8]    = 8'(j);
    end
    send_one(x, w, {16{32'hDEAD_BEEF}}, 1'b1, early);
    total++; if (bus.m_acc !== exp_acc) begin bad++; $display("FAIL rstacc_m_acc: got %h want %h", bus.m_acc, exp_acc); end
    total++; if (bus.m_out !== exp_out) begin bad++; $display("FAIL rstacc_m_out: got %h want %h", bus.m_out, exp_out); end
    @(negedge clk);
    total++; if (op_count !== 16'd3) begin bad++; $display("FAIL rstacc_op_count: got %0d want 3", op_count); end
  endtask

  // Four beats, m_ready low during loop cycles 2..6; zero weights so each
  // result equals its accumulator operand.
  task automatic test_backpressure;
    logic [511:0] exp_q [4];
    int sent, recv, first_drop;
    logic accept;
    sent = 0; recv = 0; first_drop = -1;
    for (int k = 0; k < 4; k++) exp_q[k] = {16{32'(k*7 + 100)}};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.m_ready = !(c >= 2 && c <= 6);
      if (sent < 4) drive('0, '0, exp_q[sent], 1'b0); else idle;
      #1;
      if (bus.s_valid && !bus.s_ready && first_drop < 0) first_drop = sent;
      if (c == 6) begin
        total++; if (bus.m_valid !== 1'b1 || bus.m_acc !== exp_q[0]) begin
          bad++; $display("FAIL bp_hold: got valid=%b acc=%h want valid=1 acc=%h", bus.m_valid, bus.m_acc, exp_q[0]);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        total++;
        if (recv >= 4) begin
          bad++; $display("FAIL bp_extra: got beat %0d want at most 4", recv + 1);
        end else if (bus.m_acc !== exp_q[recv]) begin
          bad++; $display("FAIL bp_order[%0d]: got %h want %h", recv, bus.m_acc, exp_q[recv]);
        end
        recv++;
      end
      accept = bus.s_valid && bus.s_ready;
      @(posedge clk);
      if (accept) sent++;
    end
    @(negedge clk);
    idle;
    bus.m_ready = 1'b1;
    total++; if (first_drop !== 2) begin bad++; $display("FAIL bp_first_drop: got %0d want 2", first_drop); end
    total++; if (recv !== 4) begin bad++; $display("FAIL bp_count: got %0d want 4", recv); end
    total++; if (op_count !== 16'd7) begin bad++; $display("FAIL bp_op_count: got %0d want 7", op_count); end
  endtask

  // 100 random beats at full rate; result k shows two loop iterations later.
  task automatic test_back_to_back;
    logic [127:0]  si [100];
    logic [2047:0] sw [100];
    logic [511:0]  sa [100];
    logic          sr [100];
    logic [511:0]  exp_acc;
    int drops, errs;
    drops = 0; errs = 0;
    for (int k = 0; k < 100; k++) begin
      for (int b = 0; b < 4; b++)  si[k][b*32 +: 32] = $urandom;
      for (int b = 0; b < 64; b++) sw[k][b*32 +: 32] = $urandom;
      for (int b = 0; b < 16; b++) sa[k][b*32 +: 32] = $urandom;
      sr[k] = ($urandom_range(0, 3) == 0);
    end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 102; c++) begin
      @(negedge clk);
      if (c < 100) drive(si[c], sw[c], sa[c], sr[c]); else idle;
      #1;
      if (c < 100 && bus.s_ready !== 1'b1) drops++;
      if (c >= 2) begin
        exp_acc = ref_gemm(si[c-2], sw[c-2], sa[c-2], sr[c-2]);
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_acc !== exp_acc || bus.m_out !== narrow(exp_acc)) begin
          bad++; errs++;
          if (errs <= 3) $display("FAIL stream[%0d]: got valid=%b acc=%h want valid=1 acc=%h", c - 2, bus.m_valid, bus.m_acc, exp_acc);
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    total++; if (drops !== 0) begin bad++; $display("FAIL stream_s_ready: got %0d stalls want 0", drops); end
    total++; if (op_count !== 16'd107) begin bad++; $display("FAIL stream_op_count: got %0d want 107", op_count); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL stream_drained: got %b want 0", bus.m_valid); end
  endtask

  task automatic test_async_reset;
    int stale;
    stale = 0;
    @(negedge clk);
    bus.m_ready = 1'b0;
    drive({16{8'h01}}, {256{8'h01}}, {16{32'd1}}, 1'b0);
    @(negedge clk);
    drive({16{8'h02}}, {256{8'h01}}, {16{32'd2}}, 1'b0);
    @(negedge clk);
    idle;
    total++; if (busy !== 1'b1 || bus.m_valid !== 1'b1) begin bad++; $display("FAIL arst_pre: got busy=%b valid=%b want 1 1", busy, bus.m_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL arst_m_valid: got %b want 0", bus.m_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL arst_op_count: got %0d want 0", op_count); end
    total++; if (bus.m_acc !== 512'd0) begin bad++; $display("FAIL arst_m_acc: got %h want 0", bus.m_acc); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL arst_stale: got %0d cycles want 0", stale); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL arst_s_ready: got %b want 1", bus.s_ready); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL arst_op_after: got %0d want 0", op_count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_signed_wrap;
    test_reset_acc;
    test_backpressure;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
